mod_n_counter: RTL

//   Parametrised modulo-N up/down counter; generic timebase digit for stopwatch/timer datapaths.

---
 rtl/mod_n_counter.sv | 102 ++++++++++
 1 files changed

// File: rtl/mod_n_counter.sv
// Modulo-N up/down counter digit with preset load, wrap/saturate mode and cascade carry.
// Optional registered 3-digit BCD view of the count when BCD_OUT_EN is defined.
module mod_n_counter #(
    parameter int WIDTH   = 8,
    parameter int MODULUS = 100,
    parameter bit WRAP    = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             carry,
    output logic             at_max,
    output logic             at_min,
    output logic             load_err
`ifdef BCD_OUT_EN
    ,
    output logic [11:0]      bcd
`endif
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULUS - 1);
    // One extra bit so MODULUS == 2**WIDTH still compares correctly.
    localparam logic [WIDTH:0]   MOD_X   = (WIDTH + 1)'(MODULUS);

    if (MODULUS < 2 || (WIDTH < 31 && (1 << WIDTH) < MODULUS)) begin : g_bad_param
        $error("mod_n_counter: illegal WIDTH/MODULUS combination");
    end

    logic [WIDTH-1:0] count_q, count_d;
    logic             load_err_q, load_err_d;
    logic             step;

    assign at_max = (count_q == MAX_VAL);
    assign at_min = (count_q == '0);
    assign step   = en & ~clr & ~load;
    assign carry  = step & (up_dn ? at_max : at_min);

    // Increment/decrement only happen away from the terminal value, so no overflow.
    always_comb begin
        count_d    = count_q;
        load_err_d = 1'b0;
        if (clr) begin
            count_d = '0;
        end else if (load) begin
            if ({1'b0, load_val} < MOD_X) begin
                count_d = load_val;
            end else begin
                count_d    = MAX_VAL;
                load_err_d = 1'b1;
            end
        end else if (en) begin
            if (up_dn) begin
                if (at_max) count_d = WRAP ? '0 : count_q;
                else        count_d = count_q + 1'b1;
            end else begin
                if (at_min) count_d = WRAP ? MAX_VAL : count_q;
                else        count_d = count_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q    <= '0;
            load_err_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            load_err_q <= load_err_d;
        end
    end

    assign count    = count_q;
    assign load_err = load_err_q;

`ifdef BCD_OUT_EN
    if (MODULUS > 1000) begin : g_bad_bcd
        $error("mod_n_counter: BCD_OUT_EN requires MODULUS <= 1000");
    end

    function automatic logic [11:0] to_bcd(input logic [WIDTH-1:0] v);
        int n;
        n = int'(v);
        return {4'((n / 100) % 10), 4'((n / 10) % 10), 4'(n % 10)};
    endfunction

    logic [11:0] bcd_q;

    // Converted from the next count so bcd and count change on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) bcd_q <= 12'h000;
        else        bcd_q <= to_bcd(count_d);
    end

    assign bcd = bcd_q;
`endif

endmodule
